fu_alu_rs: RTL

ALU reservation station: the issue stage directly upstream of `fu_alu`.
- Buffers up to `DEPTH` dispatched ALU ops and captures pending source operands from the common data bus (CDB).
- Selects one ready op per cycle and presents it on registered `port_a`/`port_b`/`aluop` outputs that drive the ALU interface.
- Backpressure from writeback stalls the issue register without losing entries.

---
 rtl/fu_alu_rs_if.sv | 38 +++
 rtl/fu_alu_rs.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fu_alu_rs_if.sv
// fu_alu_rs_if: dispatch, CDB, flush, issue and status signals of the ALU reservation station
interface fu_alu_rs_if #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
);
    logic                       disp_valid;
    logic                       disp_ready;
    logic [3:0]                 disp_aluop;
    logic [TAG_W-1:0]           disp_tag_a;
    logic [TAG_W-1:0]           disp_tag_b;
    logic [DATA_W-1:0]          disp_val_a;
    logic [DATA_W-1:0]          disp_val_b;
    logic [TAG_W-1:0]           disp_dest;
    logic                       cdb_valid;
    logic [TAG_W-1:0]           cdb_tag;
    logic [DATA_W-1:0]          cdb_value;
    logic                       flush;
    logic                       iss_valid;
    logic                       iss_ready;
    logic [DATA_W-1:0]          port_a;
    logic [DATA_W-1:0]          port_b;
    logic [3:0]                 aluop;
    logic [TAG_W-1:0]           iss_dest;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    modport master (
        output disp_valid, disp_aluop, disp_tag_a, disp_tag_b, disp_val_a, disp_val_b, disp_dest,
        output cdb_valid, cdb_tag, cdb_value, flush, iss_ready,
        input  disp_ready, iss_valid, port_a, port_b, aluop, iss_dest, occupancy
    );

    modport slave (
        input  disp_valid, disp_aluop, disp_tag_a, disp_tag_b, disp_val_a, disp_val_b, disp_dest,
        input  cdb_valid, cdb_tag, cdb_value, flush, iss_ready,
        output disp_ready, iss_valid, port_a, port_b, aluop, iss_dest, occupancy
    );
endinterface

// File: rtl/fu_alu_rs.sv
// fu_alu_rs: ALU reservation station with CDB wakeup, dispatch bypass and a registered issue stage; FU_ALU_RS_AGE_EN selects oldest-ready issue instead of lowest-index
module fu_alu_rs #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input logic        CLK,
    input logic        nRST,
    fu_alu_rs_if.slave rs
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  e_valid;
    logic [3:0]        e_op   [DEPTH];
    logic [TAG_W-1:0]  e_ta   [DEPTH];
    logic [TAG_W-1:0]  e_tb   [DEPTH];
    logic [TAG_W-1:0]  e_dest [DEPTH];
    logic [DATA_W-1:0] e_va   [DEPTH];
    logic [DATA_W-1:0] e_vb   [DEPTH];
    logic [DEPTH-1:0]  rdy;
    logic [IW-1:0]     sel;
    logic [IW-1:0]     slot;
    logic [OW-1:0]     occ;
    logic              any_rdy;
    logic              cdb_hit;
    logic              byp_a;
    logic              byp_b;
    logic              disp_fire;
    logic              load;
    logic              take;
`ifdef FU_ALU_RS_AGE_EN
    logic [IW-1:0]     e_age  [DEPTH];
`endif

    assign cdb_hit      = rs.cdb_valid && rs.cdb_tag != '0;
    assign byp_a        = cdb_hit && rs.disp_tag_a == rs.cdb_tag;
    assign byp_b        = cdb_hit && rs.disp_tag_b == rs.cdb_tag;
    assign rs.occupancy = occ;
    assign rs.disp_ready = occ < OW'(DEPTH);
    assign disp_fire    = rs.disp_valid && rs.disp_ready;
    assign load         = !rs.iss_valid || rs.iss_ready;
    assign take         = load && any_rdy;

    // Count entries, find the lowest free slot and pick the ready entry to issue, all from registered state
    always_comb begin
        occ     = '0;
        rdy     = '0;
        slot    = '0;
        sel     = '0;
        any_rdy = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            occ    = occ + OW'(e_valid[i]);
            rdy[i] = e_valid[i] && e_ta[i] == '0 && e_tb[i] == '0;
            if (!e_valid[i]) slot = IW'(i);
        end
        for (int i = 0; i < DEPTH; i++)
`ifdef FU_ALU_RS_AGE_EN
            if (rdy[i] && (!any_rdy || e_age[i] > e_age[sel])) begin
`else
            if (rdy[i] && !any_rdy) begin
`endif
                sel     = IW'(i);
                any_rdy = 1'b1;
            end
    end

    // Entry payload: CDB wakeup of waiting operands and dispatch writes with same-cycle bypass
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_hit && e_ta[i] == rs.cdb_tag) begin
                e_ta[i] <= '0;
                e_va[i] <= rs.cdb_value;
            end
            if (cdb_hit && e_tb[i] == rs.cdb_tag) begin
                e_tb[i] <= '0;
                e_vb[i] <= rs.cdb_value;
            end
        end
        if (disp_fire) begin
            e_op[slot]   <= rs.disp_aluop;
            e_dest[slot] <= rs.disp_dest;
            e_ta[slot]   <= byp_a ? '0 : rs.disp_tag_a;
            e_tb[slot]   <= byp_b ? '0 : rs.disp_tag_b;
            e_va[slot]   <= byp_a ? rs.cdb_value : rs.disp_val_a;
            e_vb[slot]   <= byp_b ? rs.cdb_value : rs.disp_val_b;
        end
    end

    // Entry valid bits and the issue register; flush wins over dispatch and issue
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            e_valid      <= '0;
            rs.iss_valid <= 1'b0;
            rs.port_a    <= '0;
            rs.port_b    <= '0;
            rs.aluop     <= '0;
            rs.iss_dest  <= '0;
        end else if (rs.flush) begin
            e_valid      <= '0;
            rs.iss_valid <= 1'b0;
        end else begin
            if (take) e_valid[sel] <= 1'b0;
            if (disp_fire) e_valid[slot] <= 1'b1;
            if (load) rs.iss_valid <= any_rdy;
            if (take) begin
                rs.port_a   <= e_va[sel];
                rs.port_b   <= e_vb[sel];
                rs.aluop    <= e_op[sel];
                rs.iss_dest <= e_dest[sel];
            end
        end
    end

`ifdef FU_ALU_RS_AGE_EN
    // Age rank = number of younger valid entries; new entries start at 0, older ranks close up when an entry leaves
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            for (int i = 0; i < DEPTH; i++) e_age[i] <= '0;
        else
            for (int i = 0; i < DEPTH; i++)
                e_age[i] <= (disp_fire && IW'(i) == slot) ? '0
                          : e_age[i] + IW'(disp_fire && e_valid[i])
                                     - IW'(take && e_valid[i] && e_age[i] > e_age[sel]);
    end
`endif
endmodule
